// File: rtl/keypad_entry_if.sv
// Keypad entry bus: encoder-side key inputs, operator controls and entry/code outputs.
interface keypad_entry_if #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CW       = 3
);
    logic [3:0]            d_in;
    logic                  loadn;
    logic                  clear;
    logic                  enter;
    logic                  enable;
    logic [4*N_DIGITS-1:0] digits;
    logic [CW-1:0]         digit_count;
    logic                  key_strobe;
    logic [4*N_DIGITS-1:0] code_out;
    logic                  code_valid;

    modport master (
        output d_in, loadn, clear, enter,
        input  enable, digits, digit_count, key_strobe, code_out, code_valid
    );

    modport slave (
        input  d_in, loadn, clear, enter,
        output enable, digits, digit_count, key_strobe, code_out, code_valid
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Debounced keypad digit entry: one digit per press into a BCD shift buffer,
// published as a code word on enter; blocks the keypad while the buffer is full.
module keypad_entry_ctrl #(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CW        = 3
) (
    input logic           clk,
    input logic           rst_n,
    keypad_entry_if.slave bus
);
    localparam int unsigned DW    = 4 * N_DIGITS;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES);
    localparam logic [CW-1:0]    FULL    = CW'(N_DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc_c;
    logic [3:0]        cand, cand_n;
    logic              accept_c;
    logic              key_ok_c;

    logic [DW-1:0]     digits_r, digits_n;
    logic [DW-1:0]     code_r, code_n;
    logic [CW-1:0]     count_r, count_n;
    logic              strobe_r, strobe_n;
    logic              valid_r, valid_n;
    logic              enable_r, enable_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            digits_r <= '0;
            code_r   <= '0;
            count_r  <= '0;
            strobe_r <= 1'b0;
            valid_r  <= 1'b0;
            enable_r <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cand     <= cand_n;
            digits_r <= digits_n;
            code_r   <= code_n;
            count_r  <= count_n;
            strobe_r <= strobe_n;
            valid_r  <= valid_n;
            enable_r <= enable_n;
        end
    end

    // Debounce FSM; a non-BCD code counts as a released key while debouncing a press.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        accept_c  = 1'b0;
        cnt_inc_c = cnt + CNT_W'(1);
        key_ok_c  = !bus.loadn && (bus.d_in <= 4'd9);
        case (state)
            IDLE: begin
                if (!bus.loadn) begin
                    cand_n  = bus.d_in;
                    cnt_n   = CNT_W'(1);
                    state_n = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!key_ok_c) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (bus.d_in != cand) begin
                    cand_n = bus.d_in;
                    cnt_n  = CNT_W'(1);
                end else if (cnt_inc_c == DB_LAST) begin
                    accept_c = 1'b1;
                    cnt_n    = '0;
                    state_n  = HELD;
                end else begin
                    cnt_n = cnt_inc_c;
                end
            end
            HELD: begin
                if (bus.loadn) begin
                    cnt_n   = CNT_W'(1);
                    state_n = REL_DB;
                end
            end
            REL_DB: begin
                if (!bus.loadn) begin
                    cnt_n   = '0;
                    state_n = HELD;
                end else if (cnt_inc_c == DB_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc_c;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Buffer update: clear wins outright; enter empties first, then a same-cycle accept lands on top.
    always_comb begin
        digits_n = digits_r;
        count_n  = count_r;
        code_n   = code_r;
        strobe_n = 1'b0;
        valid_n  = 1'b0;
        enable_n = (count_r == FULL);
        if (bus.clear) begin
            digits_n = '0;
            count_n  = '0;
        end else begin
            if (bus.enter && (count_r != '0)) begin
                code_n   = digits_r;
                valid_n  = 1'b1;
                digits_n = '0;
                count_n  = '0;
            end
            if (accept_c && (count_n < FULL)) begin
                digits_n = {digits_n[DW-5:0], cand};
                count_n  = count_n + CW'(1);
                strobe_n = 1'b1;
            end
        end
    end

    assign bus.digits      = digits_r;
    assign bus.digit_count = count_r;
    assign bus.code_out    = code_r;
    assign bus.key_strobe  = strobe_r;
    assign bus.code_valid  = valid_r;
    assign bus.enable      = enable_r;
endmodule
